multi_chan_fifo: RTL

Single-clock FIFO with `NUM_CHANNELS` independent queues, each `2**LOG_DEPTH` entries deep, in per-channel flop storage. Accepts at most one push and one pop per cycle, each steered by a channel index. It is the synchronous, multi-channel successor to the gray-pointer CDC FIFO. It buffers interleaved traffic (e.g. per-ID responses) inside a single clock domain, ahead of per-channel consumers.

---
 rtl/multi_chan_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/multi_chan_fifo.sv
// Single-clock FIFO with NUM_CHANNELS independent flop-based queues, one push and one pop per cycle.
// Optional per-channel flush is built only when MULTI_CHAN_FIFO_FLUSH_EN is defined.
module multi_chan_fifo #(
    parameter int  WIDTH        = 8,
    parameter type T            = logic [WIDTH-1:0],
    parameter int  LOG_DEPTH    = 2,
    parameter int  NUM_CHANNELS = 4,
    localparam int ChanW        = $clog2(NUM_CHANNELS),
    localparam int PtrW         = LOG_DEPTH + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic [ChanW-1:0]            src_chan_i,
    input  T                            src_data_i,
    input  logic                        src_valid_i,
    output logic                        src_ready_o,
    input  logic [ChanW-1:0]            dst_chan_i,
    output T                            dst_data_o,
    output logic                        dst_valid_o,
    input  logic                        dst_ready_i,
    output logic [NUM_CHANNELS*PtrW-1:0] usage_o,
    input  logic [NUM_CHANNELS-1:0]     flush_i
);

    localparam int Depth = 2 ** LOG_DEPTH;

    logic [PtrW-1:0]         r_wptr [NUM_CHANNELS];
    logic [PtrW-1:0]         r_rptr [NUM_CHANNELS];
    T                        r_mem  [NUM_CHANNELS][Depth];

    logic [NUM_CHANNELS-1:0] w_full;
    logic [NUM_CHANNELS-1:0] w_empty;
    logic                    w_src_ready;
    logic                    w_dst_valid;
    T                        w_dst_data;
    logic                    w_push;
    logic                    w_pop;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_empty[c] = (r_wptr[c] == r_rptr[c]);
            w_full[c]  = ((r_wptr[c] ^ r_rptr[c]) == (PtrW'(1) << LOG_DEPTH));
        end
    end

    // Handshake qualifiers depend only on registered pointers and the channel index;
    // an out-of-range index matches no channel and so stays low.
    always_comb begin
        w_src_ready = 1'b0;
        w_dst_valid = 1'b0;
        w_dst_data  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (32'(src_chan_i) == c) w_src_ready = ~w_full[c];
            if (32'(dst_chan_i) == c) begin
                w_dst_valid = ~w_empty[c];
                w_dst_data  = r_mem[c][r_rptr[c][LOG_DEPTH-1:0]];
            end
        end
        w_src_ready = w_src_ready & ~clr_i;
        w_dst_valid = w_dst_valid & ~clr_i;
    end

    assign src_ready_o = w_src_ready;
    assign dst_valid_o = w_dst_valid;
    assign dst_data_o  = w_dst_data;
    assign w_push      = src_valid_i & w_src_ready;
    assign w_pop       = dst_ready_i & w_dst_valid;

    always_comb begin
        usage_o = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            usage_o[c*PtrW +: PtrW] = r_wptr[c] - r_rptr[c];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
        end else if (clr_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_push && 32'(src_chan_i) == c) r_wptr[c] <= r_wptr[c] + PtrW'(1);
`ifdef MULTI_CHAN_FIFO_FLUSH_EN
                // Flush discards everything queued before this edge; a same-cycle push survives.
                if (flush_i[c]) begin
                    r_rptr[c] <= r_wptr[c];
                end else if (w_pop && 32'(dst_chan_i) == c) begin
                    r_rptr[c] <= r_rptr[c] + PtrW'(1);
                end
`else
                if (w_pop && 32'(dst_chan_i) == c) r_rptr[c] <= r_rptr[c] + PtrW'(1);
`endif
            end
        end
    end

`ifndef MULTI_CHAN_FIFO_FLUSH_EN
    logic w_unused_flush;
    assign w_unused_flush = ^flush_i;
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_push && 32'(src_chan_i) == c) begin
                r_mem[c][r_wptr[c][LOG_DEPTH-1:0]] <= src_data_i;
            end
        end
    end

endmodule
